pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 160, meaning the payload width in bits (aluop, alusel, operands, wd, wreg, pc, offset, jump status packed by the instantiating stage).
REQ-002 The block SHALL have parameter SKID, default 1: 1 gives a two-entry skid buffer with registered in_ready, 0 gives a single register with combinational in_ready.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the bubble counter.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes occur on the rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-low; rst==0 at a rising clk edge resets the block.
REQ-006 The block SHALL have port in_valid  input  1  upstream holds a valid payload.
REQ-007 The block SHALL have port in_ready  output  1  the stage accepts a payload this cycle.
REQ-008 The block SHALL have port in_data  input  DATA_W  upstream payload.
REQ-009 The block SHALL have port out_valid  output  1  out_data is valid.
REQ-010 The block SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-011 The block SHALL have port out_data  output  DATA_W  head payload, all-zero (NOP) whenever out_valid==0.
REQ-012 The block SHALL have port hold  input  1  external stall; freezes both sides of the stage.
REQ-013 The block SHALL have port flush  input  1  jump-mispredict kill; discards all held payloads.
REQ-014 The block SHALL have port occupancy  output  2  number of held entries, 0..2.
REQ-015 The block SHALL have port bubble_cnt  output  CNT_W  count of NOP cycles presented downstream.

Function
REQ-016 An accept SHALL occur when in_valid && in_ready; a release SHALL occur when out_valid && out_ready.
REQ-017 Latency SHALL be one cycle: a payload accepted into an empty stage appears on out_data with out_valid=1 on the next cycle.
REQ-018 Payloads SHALL leave in acceptance order; the head is the main register, and the skid entry moves to the head on release.
REQ-019 With SKID=1, in_ready SHALL be a register equal to (skid entry empty) && !hold && !flush, sustaining one payload per cycle under continuous out_ready.
REQ-020 With SKID=0, in_ready SHALL equal (!out_valid || out_ready) && !hold && !flush, and occupancy SHALL never exceed 1.
REQ-021 While hold==1: out_valid SHALL be 0, no accept or release SHALL occur, and held contents SHALL be retained unchanged.
REQ-022 While flush==1: in the next cycle, occupancy SHALL be 0, out_valid 0, and out_data zero; flush SHALL take priority over hold, accept and release; any in_data presented that cycle SHALL be dropped.
REQ-023 A simultaneous accept and release SHALL leave occupancy unchanged.
REQ-024 When an entry empties, its data register SHALL be cleared to zero.
REQ-025 bubble_cnt SHALL increment by 1 each cycle with out_valid==0 && hold==0; it SHALL saturate at 2^CNT_W-1 and be cleared only by reset.

Reset
REQ-026 At reset, out_valid, occupancy, out_data, skid contents and bubble_cnt SHALL be 0, and in_ready SHALL be 0 in the reset cycle and 1 in the first cycle after.
REQ-027 Reset during an active transfer SHALL discard all entries, and reset SHALL override flush and hold.

Structure
REQ-028 The NOP payload constant and the default DATA_W field layout (EX_NOP, EX_RES_NOP, ZeroWord, NOPRegAddr) SHALL reside in the shared defines package.
REQ-029 The saturating counter SHALL be one sub-module, sat_counter, and the rest of the block SHALL be flat.

Verification
REQ-030 The bench SHALL cover: reset, then one accept of 0xABCD with out_ready=1 -> out_valid=1 with out_data=0xABCD at cycle+1, and occupancy returns to 0 at cycle+2.
REQ-031 The bench SHALL cover: SKID=1, out_ready=0, two payloads A and B -> occupancy=2 and in_ready=0; then out_ready=1 -> A, then B, on consecutive cycles.
REQ-032 The bench SHALL cover: occupancy=2 plus flush=1 with in_valid=1 -> next cycle occupancy=0, out_data=0, and the input payload absent downstream.
REQ-033 The bench SHALL cover: hold=1 for 3 cycles with occupancy=1 -> out_valid=0 throughout, bubble_cnt unchanged, and the same payload out on release.
REQ-034 The bench SHALL cover: CNT_W=4, 20 empty non-held cycles -> bubble_cnt=15.
REQ-035 The bench SHALL cover: rst=0 asserted with occupancy=2 -> next cycle all outputs 0 and no stale payload released.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared defines for the EX pipeline stage register: NOP encodings and the
// default payload field layout packed by the issuing stage.
package pipe_stage_reg_pkg;

  localparam logic [7:0]  EX_NOP      = 8'h00;
  localparam logic [2:0]  EX_RES_NOP  = 3'b000;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr  = 5'b00000;
  localparam int          JUMP_STAT_W = 15;

  typedef struct packed {
    logic [7:0]             aluOp;
    logic [2:0]             aluSel;
    logic [31:0]            reg1;
    logic [31:0]            reg2;
    logic [4:0]             wd;
    logic                   wreg;
    logic [31:0]            pc;
    logic [31:0]            offset;
    logic [JUMP_STAT_W-1:0] jumpStat;
  } ex_payload_t;

  localparam int EX_PAYLOAD_W = $bits(ex_payload_t);

  localparam ex_payload_t EX_NOP_PAYLOAD = '{
    aluOp:    EX_NOP,
    aluSel:   EX_RES_NOP,
    reg1:     ZeroWord,
    reg2:     ZeroWord,
    wd:       NOPRegAddr,
    wreg:     1'b0,
    pc:       ZeroWord,
    offset:   ZeroWord,
    jumpStat: '0
  };

  function automatic logic [1:0] countEntries(input logic headValid, input logic skidValid);
    return {1'b0, headValid} + {1'b0, skidValid};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rstN,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional skid entry, stall (hold),
// mispredict flush and a saturating count of bubbles shown downstream.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 160,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              hold,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(EX_NOP_PAYLOAD);

  logic              r_headValid;
  logic              r_skidValid;
  logic              r_inReady;
  logic [DATA_W-1:0] r_headData;
  logic [DATA_W-1:0] r_skidData;

  logic              w_headValidNext;
  logic              w_skidValidNext;
  logic [DATA_W-1:0] w_headDataNext;
  logic [DATA_W-1:0] w_skidDataNext;
  logic              w_frontOpen;
  logic              w_accept;
  logic              w_release;
  logic              w_bubble;

  assign out_valid   = r_headValid && !hold && !flush;
  assign w_frontOpen = (SKID != 0) ? 1'b1 : (!out_valid || out_ready);
  assign in_ready    = r_inReady && w_frontOpen && !hold && !flush;
  assign w_accept    = in_valid && in_ready;
  assign w_release   = out_valid && out_ready;
  assign out_data    = out_valid ? r_headData : NOP_WORD;
  assign occupancy   = countEntries(r_headValid, r_skidValid);
  assign w_bubble    = !out_valid && !hold;

  // Hold needs no branch of its own: it already blocks accept and release.
  always_comb begin
    w_headValidNext = r_headValid;
    w_headDataNext  = r_headData;
    w_skidValidNext = r_skidValid;
    w_skidDataNext  = r_skidData;
    if (flush) begin
      w_headValidNext = 1'b0;
      w_headDataNext  = '0;
      w_skidValidNext = 1'b0;
      w_skidDataNext  = '0;
    end else if (w_release && r_skidValid) begin
      w_headDataNext  = r_skidData;
      w_skidValidNext = 1'b0;
      w_skidDataNext  = '0;
    end else if (w_release && w_accept) begin
      w_headDataNext  = in_data;
    end else if (w_release) begin
      w_headValidNext = 1'b0;
      w_headDataNext  = '0;
    end else if (w_accept && !r_headValid) begin
      w_headValidNext = 1'b1;
      w_headDataNext  = in_data;
    end else if (w_accept && (SKID != 0)) begin
      w_skidValidNext = 1'b1;
      w_skidDataNext  = in_data;
    end
  end

  // r_inReady also doubles as the "out of reset" qualifier for the flat variant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_headValid <= 1'b0;
      r_headData  <= '0;
      r_skidValid <= 1'b0;
      r_skidData  <= '0;
      r_inReady   <= 1'b0;
    end else begin
      r_headValid <= w_headValidNext;
      r_headData  <= w_headDataNext;
      r_skidValid <= w_skidValidNext;
      r_skidData  <= w_skidDataNext;
      r_inReady   <= (SKID != 0) ? !w_skidValidNext : 1'b1;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_bubbleCnt (
    .i_clk   (clk),
    .i_rstN  (rst),
    .i_inc   (w_bubble),
    .o_count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised bench for pipe_stage_reg: a skid and a flat instance share stimulus
// and are compared each cycle against a FIFO-style reference model.
module tb_pipe_stage_reg;

  localparam int DW      = 160;
  localparam int CW      = 4;
  localparam int CNT_MAX = 15;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic          hold      = 1'b0;
  logic          flush     = 1'b0;
  logic [DW-1:0] in_data   = '0;

  logic          dutInReady  [2];
  logic          dutOutValid [2];
  logic [DW-1:0] dutOutData  [2];
  logic [1:0]    dutOcc      [2];
  logic [CW-1:0] dutBubble   [2];

  int vectorCount = 0;
  int miscompares = 0;

  logic [DW-1:0] mEntry [2][2];
  int            mCount [2];
  int            mBubble[2];
  bit            mInReset;

  pipe_stage_reg #(.DATA_W(DW), .SKID(1), .CNT_W(CW)) u_dutSkid (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (dutInReady[0]),
    .in_data    (in_data),
    .out_valid  (dutOutValid[0]),
    .out_ready  (out_ready),
    .out_data   (dutOutData[0]),
    .hold       (hold),
    .flush      (flush),
    .occupancy  (dutOcc[0]),
    .bubble_cnt (dutBubble[0])
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID(0), .CNT_W(CW)) u_dutFlat (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (dutInReady[1]),
    .in_data    (in_data),
    .out_valid  (dutOutValid[1]),
    .out_ready  (out_ready),
    .out_data   (dutOutData[1]),
    .hold       (hold),
    .flush      (flush),
    .occupancy  (dutOcc[1]),
    .bubble_cnt (dutBubble[1])
  );

  always #5 clk = ~clk;

  function automatic bit expOutValid(input int i);
    return (mCount[i] > 0) && !hold && !flush;
  endfunction

  function automatic bit expInReady(input int i);
    if (mInReset || hold || flush) return 1'b0;
    if (i == 0) return mCount[0] < 2;
    return (mCount[1] == 0) || out_ready;
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("out_valid[%0d]", i), DW'(dutOutValid[i]), DW'(expOutValid(i)));
      checkOutput($sformatf("out_data[%0d]", i), dutOutData[i], expOutValid(i) ? mEntry[i][0] : '0);
      checkOutput($sformatf("in_ready[%0d]", i), DW'(dutInReady[i]), DW'(expInReady(i)));
      checkOutput($sformatf("occupancy[%0d]", i), DW'(dutOcc[i]), DW'(mCount[i]));
      checkOutput($sformatf("bubble_cnt[%0d]", i), DW'(dutBubble[i]), DW'(mBubble[i]));
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic ordy,
                               input logic h, input logic f, input logic r);
    bit acc[2];
    bit rel[2];
    bit bub[2];
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    hold      = h;
    flush     = f;
    rst       = r;
    @(negedge clk);
    checkAll();
    for (int i = 0; i < 2; i++) begin
      acc[i] = iv && expInReady(i);
      rel[i] = expOutValid(i) && ordy;
      bub[i] = !expOutValid(i) && !h;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        mCount[i]  = 0;
        mBubble[i] = 0;
      end else begin
        if (bub[i] && mBubble[i] < CNT_MAX) mBubble[i]++;
        if (f) begin
          mCount[i] = 0;
        end else begin
          if (rel[i]) begin
            mEntry[i][0] = mEntry[i][1];
            mCount[i]--;
          end
          if (acc[i]) begin
            mEntry[i][mCount[i]] = d;
            mCount[i]++;
          end
        end
      end
    end
    mInReset = !r;
  endtask

  function automatic logic [DW-1:0] randWord();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [DW-1:0] pa;
    logic [DW-1:0] pb;
    pa = DW'('hA5A5_0001);
    pb = DW'('h5A5A_0002);

    rst = 1'b0;
    @(posedge clk);
    #1;
    mInReset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mCount[i]  = 0;
      mBubble[i] = 0;
    end

    $display("[TB] reset and single transfer");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, DW'('hABCD), 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("abcd_valid", DW'(dutOutValid[0]), DW'(1));
    checkOutput("abcd_data", dutOutData[0], DW'('hABCD));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] skid fill and drain");
    applyStimulus(1'b1, pa, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, pb, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("skid_full_occ", DW'(dutOcc[0]), DW'(2));
    checkOutput("skid_full_ready", DW'(dutInReady[0]), DW'(0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("drain_second", dutOutData[0], pb);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] flush while full");
    applyStimulus(1'b1, DW'('hC0C0), 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, DW'('hD0D0), 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, DW'('hE0E0), 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_occ", DW'(dutOcc[0]), DW'(0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_data", dutOutData[0], '0);

    $display("[TB] hold with one entry");
    applyStimulus(1'b1, DW'('hF00F), 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, DW'('h1234), 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] bubble counter saturation");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("bubble_sat", DW'(dutBubble[0]), DW'(15));

    $display("[TB] reset while full");
    applyStimulus(1'b1, DW'('h4444), 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, DW'('h5555), 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, DW'('h6666), 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_occ", DW'(dutOcc[0]), DW'(0));
    checkOutput("rst_bubble", DW'(dutBubble[0]), DW'(0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(99) < 70, randWord(), $urandom_range(99) < 60,
                    $urandom_range(99) < 10, $urandom_range(99) < 5,
                    !($urandom_range(99) < 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
    $finish;
  end

endmodule
